// File: rtl/decoder_pkg.sv
// Shared definitions for the instruction decode queue.
//   - op_class encodings presented on the op_class output
//   - opcode byte constants and size-field values for load/store
//   - bit positions of the decoded fields in the 32-bit instruction word
//   - decode_class(): maps the top ten bits of a word to its op class
package decoder_pkg;

    typedef enum logic [2:0] {
        CLS_IDLE_NOP = 3'd0,
        CLS_ADD64    = 3'd1,
        CLS_ADD32    = 3'd2,
        CLS_SUB64    = 3'd3,
        CLS_LDR      = 3'd4,
        CLS_STR      = 3'd5,
        CLS_INVALID  = 3'd7
    } op_class_e;

    localparam logic [7:0] OPC_ADD64 = 8'h91;
    localparam logic [7:0] OPC_ADD32 = 8'h11;
    localparam logic [7:0] OPC_SUB64 = 8'hD1;
    localparam logic [7:0] OPC_LDST  = 8'hF9;

    // Size/opc field [23:22] distinguishing load from store under OPC_LDST.
    localparam logic [1:0] SZ_LDR = 2'b01;
    localparam logic [1:0] SZ_STR = 2'b00;

    localparam int RD_LSB  = 0;
    localparam int RN_LSB  = 5;
    localparam int IMM_LSB = 10;
    localparam int SH_BIT  = 22;

    // Only bits [31:22] take part in classification, so only they are passed.
    function automatic op_class_e decode_class(input logic [31:22] hi);
        op_class_e cls;
        cls = CLS_INVALID;
        case (hi[31:24])
            OPC_ADD64: cls = CLS_ADD64;
            OPC_ADD32: cls = CLS_ADD32;
            OPC_SUB64: cls = CLS_SUB64;
            OPC_LDST: begin
                if (hi[23:22] == SZ_LDR) begin
                    cls = CLS_LDR;
                end else if (hi[23:22] == SZ_STR) begin
                    cls = CLS_STR;
                end
            end
            default: cls = CLS_INVALID;
        endcase
        return cls;
    endfunction

    function automatic logic is_mem_class(input op_class_e cls);
        return (cls == CLS_LDR) || (cls == CLS_STR);
    endfunction

    function automatic logic is_alu_class(input op_class_e cls);
        return (cls == CLS_ADD64) || (cls == CLS_ADD32) || (cls == CLS_SUB64);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding raw instruction words ahead of the decoder.
//   clk, reset (async, active-low)
//   push / din   : write din when push and not full
//   pop          : drop the head when pop and not empty
//   dout         : current head (combinational read of the storage)
//   full, empty  : derived from the occupancy count
//   count        : occupancy, 0..DEPTH
module instr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = storage[rd_ptr];

    // NOTE: the storage array has no reset; stale entries are unreachable
    // because count gates every read, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            storage[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally modulo DEPTH.
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (!push_ok && pop_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_decode_queue.sv
// Buffered instruction decoder between fetch and execute/memory.
//   clk, reset (async, active-low)
//   start / ready / instruction_in : fetch-side handshake, ready = !full (registered)
//   out_valid / out_accept         : consumer handshake for the decoded record
//   op_class, rd, rn, imm12, shift12 : registered decoded fields
//   start_for_memory / ready_for_memory : memory-stage request for LDR/STR
//   mem_is_store, mem_offset       : memory request attributes (offset = imm12 << 3)
//   fifo_count                     : FIFO occupancy
//   err_count                      : saturating count of INVALID records issued
module instr_decode_queue
    import decoder_pkg::*;
#(
    parameter int WIDTH_IN  = 32,
    parameter int DEPTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   ready,
    input  logic [WIDTH_IN-1:0]    instruction_in,
    output logic                   out_valid,
    input  logic                   out_accept,
    output logic [2:0]             op_class,
    output logic [4:0]             rd,
    output logic [4:0]             rn,
    output logic [11:0]            imm12,
    output logic                   shift12,
    output logic                   start_for_memory,
    input  logic                   ready_for_memory,
    output logic                   mem_is_store,
    output logic [14:0]            mem_offset,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [ERR_CNT_W-1:0]   err_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM,
        ST_OUT
    } state_e;

    state_e               state_q;
    state_e               state_d;
    logic [WIDTH_IN-1:0]  head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_next;
    logic                 do_push;
    logic                 do_pop;
    op_class_e            head_cls;

    logic                 ready_q;
    op_class_e            cls_q;
    logic [4:0]           rd_q;
    logic [4:0]           rn_q;
    logic [11:0]          imm_q;
    logic                 sh_q;
    logic                 store_q;
    logic [ERR_CNT_W-1:0] err_q;

    instr_fifo #(
        .WIDTH (WIDTH_IN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (do_push),
        .pop   (do_pop),
        .din   (instruction_in),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign head_cls = decode_class(head[31:22]);
    assign do_push  = start && ready_q && !fifo_full;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        do_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    do_pop = 1'b1;
                end
            end
            ST_MEM: begin
                if (ready_for_memory) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_accept) begin
                    if (!fifo_empty) begin
                        do_pop = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Any pop (from IDLE or back-to-back from OUT) routes on the new head.
        if (do_pop) begin
            state_d = is_mem_class(head_cls) ? ST_MEM : ST_OUT;
        end
    end

    // Occupancy after this edge; ready is registered from it so it never
    // depends combinationally on start.
    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            cls_q   <= CLS_IDLE_NOP;
            rd_q    <= '0;
            rn_q    <= '0;
            imm_q   <= '0;
            sh_q    <= 1'b0;
            store_q <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (count_next != FULL_CNT);
            if (do_pop) begin
                cls_q   <= head_cls;
                store_q <= (head_cls == CLS_STR);
                if (head_cls == CLS_INVALID) begin
                    rd_q  <= '0;
                    rn_q  <= '0;
                    imm_q <= '0;
                    sh_q  <= 1'b0;
                    if (err_q != '1) begin
                        err_q <= err_q + 1'b1;
                    end
                end else begin
                    rd_q  <= head[RD_LSB +: 5];
                    rn_q  <= head[RN_LSB +: 5];
                    imm_q <= head[IMM_LSB +: 12];
                    sh_q  <= is_alu_class(head_cls) ? head[SH_BIT] : 1'b0;
                end
            end
        end
    end

    // All outputs come straight from registers.
    assign ready            = ready_q;
    assign out_valid        = (state_q == ST_OUT);
    assign start_for_memory = (state_q == ST_MEM);
    assign op_class         = cls_q;
    assign rd               = rd_q;
    assign rn               = rn_q;
    assign imm12            = imm_q;
    assign shift12          = sh_q;
    assign mem_is_store     = store_q;
    assign mem_offset       = {imm_q, 3'b000};
    assign fifo_count       = count;
    assign err_count        = err_q;

endmodule

// File: tb/tb_instr_decode_queue.sv
// Self-checking bench for instr_decode_queue: directed scenarios plus a
// randomized phase; a monitor compares every presented record against a
// scoreboard filled from a behavioural model of the instruction format.
module tb_instr_decode_queue;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        out_accept = 1'b0;
    logic        ready_for_memory = 1'b0;
    logic [31:0] instruction_in = '0;

    logic          ready;
    logic          out_valid;
    logic [2:0]    op_class;
    logic [4:0]    rd;
    logic [4:0]    rn;
    logic [11:0]   imm12;
    logic          shift12;
    logic          start_for_memory;
    logic          mem_is_store;
    logic [14:0]   mem_offset;
    logic [CW-1:0] fifo_count;
    logic [7:0]    err_count;

    instr_decode_queue #(
        .WIDTH_IN  (32),
        .DEPTH     (DEPTH),
        .ERR_CNT_W (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .ready            (ready),
        .instruction_in   (instruction_in),
        .out_valid        (out_valid),
        .out_accept       (out_accept),
        .op_class         (op_class),
        .rd               (rd),
        .rn               (rn),
        .imm12            (imm12),
        .shift12          (shift12),
        .start_for_memory (start_for_memory),
        .ready_for_memory (ready_for_memory),
        .mem_is_store     (mem_is_store),
        .mem_offset       (mem_offset),
        .fifo_count       (fifo_count),
        .err_count        (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cls;
        int rd;
        int rn;
        int imm;
        int sh;
    } rec_t;

    rec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_err = 0;
    bit   cur_seen = 1'b0;
    bit   rand_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference decode written from the instruction-format rules.
    function automatic rec_t model(input logic [31:0] w);
        rec_t r;
        int   opc;
        int   sz;
        opc = int'(w >> 24);
        sz  = int'((w >> 22) & 32'd3);
        r.cls = 7;
        if (opc == 'h91) r.cls = 1;
        else if (opc == 'h11) r.cls = 2;
        else if (opc == 'hD1) r.cls = 3;
        else if (opc == 'hF9 && sz == 1) r.cls = 4;
        else if (opc == 'hF9 && sz == 0) r.cls = 5;
        if (r.cls == 7) begin
            r.rd = 0; r.rn = 0; r.imm = 0; r.sh = 0;
        end else begin
            r.rd  = int'(w % 32);
            r.rn  = int'((w / 32) % 32);
            r.imm = int'((w / 1024) % 4096);
            r.sh  = (r.cls <= 3) ? int'((w >> 22) & 32'd1) : 0;
        end
        return r;
    endfunction

    // Monitor: compares whatever the DUT presents against the scoreboard head.
    always @(negedge clk) begin
        if (reset) begin
            if (start_for_memory) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_request: start_for_memory 1 with no record pending, expected 0");
                end else begin
                    check("mem_op_class", op_class, exp_q[0].cls);
                    check("mem_is_store", mem_is_store, (exp_q[0].cls == 5) ? 1 : 0);
                    check("mem_offset", mem_offset, exp_q[0].imm * 8);
                end
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out_record: out_valid 1 with no record pending, expected 0");
                end else begin
                    if (!cur_seen) begin
                        cur_seen = 1'b1;
                        if (exp_q[0].cls == 7 && exp_err < 255) exp_err++;
                    end
                    check("op_class", op_class, exp_q[0].cls);
                    check("rd", rd, exp_q[0].rd);
                    check("rn", rn, exp_q[0].rn);
                    check("imm12", imm12, exp_q[0].imm);
                    check("shift12", shift12, exp_q[0].sh);
                    check("err_count", err_count, exp_err);
                    check("no_mem_req_while_out", start_for_memory, 0);
                    if (out_accept) begin
                        void'(exp_q.pop_front());
                        cur_seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic step();
        if (rand_mode) begin
            out_accept       = ($urandom_range(0, 3) != 0);
            ready_for_memory = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w, input int limit, output bit acc);
        acc = 1'b0;
        start = 1'b1;
        instruction_in = w;
        for (int i = 0; i < limit && !acc; i++) begin
            acc = ready;  // registered, so this is the value the coming edge samples
            step();
        end
        start = 1'b0;
        if (acc) exp_q.push_back(model(w));
    endtask

    task automatic push_must(input logic [31:0] w);
        bit acc;
        push_word(w, 200, acc);
        check("push_accepted", acc, 1);
    endtask

    task automatic drain();
        rand_mode = 1'b0;
        out_accept = 1'b1;
        ready_for_memory = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) step();
        check("drain_empty", exp_q.size(), 0);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] low;
        low = $urandom();
        case ($urandom_range(0, 5))
            0: return {8'h91, low[23:0]};
            1: return {8'h11, low[23:0]};
            2: return {8'hD1, low[23:0]};
            3: return {8'hF9, 2'b01, low[21:0]};
            4: return {8'hF9, 2'b00, low[21:0]};
            default: return low;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int hc;

        // Reset state
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_start_for_memory", start_for_memory, 0);
        check("rst_op_class", op_class, 0);
        check("rst_rd", rd, 0);
        check("rst_rn", rn, 0);
        check("rst_imm12", imm12, 0);
        check("rst_shift12", shift12, 0);
        check("rst_mem_is_store", mem_is_store, 0);
        check("rst_mem_offset", mem_offset, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_err_count", err_count, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("ready_before_first_edge", ready, 0);
        @(posedge clk);
        #1;
        check("ready_after_release", ready, 1);

        // Basic ALU decode and latency
        out_accept = 1'b1;
        push_word(32'h9100_0421, 2, acc);
        check("alu_push_accepted", acc, 1);
        check("alu_valid_at_accept_edge", out_valid, 0);
        step();
        check("alu_valid_next_edge", out_valid, 1);
        check("alu_no_mem_req", start_for_memory, 0);
        step();
        check("alu_idle_after_accept", out_valid, 0);

        // Load handshake with memory stalled
        ready_for_memory = 1'b0;
        push_must(32'hF940_0862);
        hc = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (start_for_memory) begin
                hc++;
                if (hc == 4) ready_for_memory = 1'b1;
            end else if (hc > 0) begin
                break;
            end
        end
        check("ldr_mem_req_cycles", hc, 4);
        check("ldr_valid_after_mem_edge", out_valid, 1);
        ready_for_memory = 1'b0;
        step();
        check("ldr_consumed", out_valid, 0);

        // Store plus back-pressure
        out_accept = 1'b0;
        ready_for_memory = 1'b1;
        push_must(32'hF900_0862);
        push_must(32'h1100_0000);
        push_must(32'hD140_0C25);
        push_must(32'h9100_0ABC);
        push_must(32'h11C0_0FFF);
        check("full_fifo_count", fifo_count, DEPTH);
        check("full_ready_low", ready, 0);
        check("full_head_class", op_class, 5);
        push_word(32'h9100_0001, 3, acc);
        check("push_refused_when_full", acc, 0);
        check("full_count_held", fifo_count, DEPTH);
        drain();

        // INVALID records and counter saturation
        for (int i = 0; i < 3; i++) push_must(32'h0000_0000);
        drain();
        check("err_after_three", err_count, 3);
        out_accept = 1'b1;
        for (int i = 0; i < 300; i++) push_must(32'h0000_0000);
        drain();
        check("err_saturated", err_count, 255);

        // Randomized traffic
        rand_mode = 1'b1;
        for (int i = 0; i < 400; i++) push_must(rand_word());
        drain();

        // Reset during a memory handshake
        out_accept = 1'b0;
        ready_for_memory = 1'b0;
        push_must(32'hF940_0ABC);
        push_must(32'h9100_0421);
        push_must(32'h1100_0000);
        for (int i = 0; i < 20 && !start_for_memory; i++) step();
        check("mem_req_before_reset", start_for_memory, 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_start_for_memory", start_for_memory, 0);
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_fifo_count", fifo_count, 0);
        exp_q.delete();
        cur_seen = 1'b0;
        exp_err = 0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("ready_low_after_rerelease", ready, 0);
        @(posedge clk);
        #1;
        check("ready_high_after_rerelease", ready, 1);
        out_accept = 1'b1;
        push_must(32'h9100_0000);
        step();
        check("post_reset_valid", out_valid, 1);
        drain();
        check("post_reset_err_count", err_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
